leaf_ingress_demux: RTL

Receive-side leaf interface between a BFT leaf port and a page operator. Accepts 49-bit packets from the network on `din_leaf_bft2interface`, filters them by leaf address, and demultiplexes the 32-bit payloads into per-port FIFOs. Each FIFO drives a valid/ready stream into the page. A packet that cannot be stored is dropped, and a one-cycle `resend` request is raised back toward the network.

---
 rtl/leaf_ingress_demux_if.sv | 30 +++
 rtl/leaf_ingress_demux.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/leaf_ingress_demux_if.sv
// leaf_ingress_demux_if: BFT packet input plus per-port page streams.
// The slave modport is the demux side, the master modport is the network/page side.
interface leaf_ingress_demux_if #(
   parameter int unsigned NUM_PORTS = 4
);
   logic [48:0]             din_leaf_bft2interface;
   logic [NUM_PORTS*32-1:0] stream_data;
   logic [NUM_PORTS-1:0]    stream_valid;
   logic [NUM_PORTS-1:0]    stream_ready;
   logic                    resend;
   logic [2:0]              resend_port;

   modport master (
      output din_leaf_bft2interface,
      output stream_ready,
      input  stream_data,
      input  stream_valid,
      input  resend,
      input  resend_port
   );

   modport slave (
      input  din_leaf_bft2interface,
      input  stream_ready,
      output stream_data,
      output stream_valid,
      output resend,
      output resend_port
   );
endinterface

// File: rtl/leaf_ingress_demux.sv
// leaf_ingress_demux: registers BFT packets, filters them by leaf/port and
// demultiplexes payloads into per-port first-word-fall-through FIFOs.
// A packet aimed at a full FIFO is dropped and a one-cycle resend is raised.
// Optional macro LEAF_INGRESS_DROP_CNT_EN adds a saturating drop_count output.
module leaf_ingress_demux #(
   parameter logic [4:0]  MY_LEAF    = 5'd0,
   parameter int unsigned NUM_PORTS  = 4,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                ap_start,
   leaf_ingress_demux_if.slave bus
`ifdef LEAF_INGRESS_DROP_CNT_EN
   ,
   output logic [15:0]         drop_count
`endif
);
   localparam int unsigned AW      = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH_C  = (AW+1)'(FIFO_DEPTH);
   localparam logic [3:0]  NPORTS_C = 4'(NUM_PORTS);

   typedef enum logic {IDLE, RUN} state_t;

   state_t        state_q, state_d;

   logic          pkt_valid_q;
   logic [4:0]    pkt_leaf_q;
   logic [2:0]    pkt_port_q;
   logic [31:0]   pkt_data_q;

   logic [31:0]   mem_q  [NUM_PORTS][FIFO_DEPTH];
   logic [AW-1:0] wptr_q [NUM_PORTS];
   logic [AW-1:0] rptr_q [NUM_PORTS];
   logic [AW:0]   cnt_q  [NUM_PORTS];

   logic [NUM_PORTS-1:0] wr_en;
   logic [NUM_PORTS-1:0] nonempty;
   logic [NUM_PORTS-1:0] pop;
   logic          drop_cap;
   logic          drop_addr;
   logic          resend_q;
   logic [2:0]    resend_port_q;

   // Control state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // IDLE waits for ap_start; RUN is left only through reset
   always_comb begin
      state_d = state_q;
      if (state_q == IDLE && ap_start) state_d = RUN;
   end

   // Stage 0: capture the incoming packet every cycle (reserved bits not kept)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pkt_valid_q <= 1'b0;
         pkt_leaf_q  <= '0;
         pkt_port_q  <= '0;
         pkt_data_q  <= '0;
      end else begin
         pkt_valid_q <= bus.din_leaf_bft2interface[48];
         pkt_leaf_q  <= bus.din_leaf_bft2interface[47:43];
         pkt_port_q  <= bus.din_leaf_bft2interface[42:40];
         pkt_data_q  <= bus.din_leaf_bft2interface[31:0];
      end
   end

   // Stage 1 decode: address filter, then capacity check on the registered count
   always_comb begin
      wr_en     = '0;
      drop_cap  = 1'b0;
      drop_addr = 1'b0;
      if (state_q == RUN && pkt_valid_q) begin
         if (pkt_leaf_q != MY_LEAF || {1'b0, pkt_port_q} >= NPORTS_C) begin
            drop_addr = 1'b1;
         end else begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
               if (pkt_port_q == 3'(p)) begin
                  if (cnt_q[p] == DEPTH_C) drop_cap = 1'b1;
                  else                     wr_en[p] = 1'b1;
               end
            end
         end
      end
   end

   // Head-of-FIFO outputs and valid-gated pops
   always_comb begin
      nonempty         = '0;
      pop              = '0;
      bus.stream_data  = '0;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
         nonempty[p] = (cnt_q[p] != '0);
         pop[p]      = bus.stream_ready[p] & nonempty[p];
         if (nonempty[p]) bus.stream_data[p*32 +: 32] = mem_q[p][rptr_q[p]];
      end
   end

   assign bus.stream_valid = nonempty;

   // Per-FIFO pointers and occupancy
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            wptr_q[p] <= '0;
            rptr_q[p] <= '0;
            cnt_q[p]  <= '0;
         end
      end else begin
         for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (wr_en[p]) wptr_q[p] <= wptr_q[p] + 1'b1;
            if (pop[p])   rptr_q[p] <= rptr_q[p] + 1'b1;
            case ({wr_en[p], pop[p]})
               2'b10:   cnt_q[p] <= cnt_q[p] + 1'b1;
               2'b01:   cnt_q[p] <= cnt_q[p] - 1'b1;
               default: cnt_q[p] <= cnt_q[p];
            endcase
         end
      end
   end

   // FIFO storage; contents are don't-care until the count covers them
   always_ff @(posedge clk) begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
         if (wr_en[p]) mem_q[p][wptr_q[p]] <= pkt_data_q;
      end
   end

   // Resend pulse and sticky port of the latest capacity drop
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         resend_q      <= 1'b0;
         resend_port_q <= '0;
      end else begin
         resend_q <= drop_cap;
         if (drop_cap) resend_port_q <= pkt_port_q;
      end
   end

   assign bus.resend      = resend_q;
   assign bus.resend_port = resend_port_q;

`ifdef LEAF_INGRESS_DROP_CNT_EN
   logic [15:0] drop_cnt_q;

   // Saturating count of all drops seen while running
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         drop_cnt_q <= '0;
      end else if ((drop_cap || drop_addr) && drop_cnt_q != '1) begin
         drop_cnt_q <= drop_cnt_q + 1'b1;
      end
   end

   assign drop_count = drop_cnt_q;
`endif
endmodule
